// File: rtl/output_gating_pkg.sv
// output_gating_pkg
//   Shared constants and helpers for the output gating block. Defines the
//   default lane geometry, the int8 saturation bounds used by the requantizer,
//   the packed FIFO word type and a lane-slice helper.
//   No ports (package).

package output_gating_pkg;

   localparam int unsigned PKG_LANES = 16;
   localparam int unsigned PKG_IN_W  = 16;
   localparam int unsigned PKG_OUT_W = 8;
   localparam int unsigned SHIFT_W   = 4;

   // Requant saturation bounds for a signed PKG_OUT_W-bit result
   localparam int SAT_MAX = (1 << (PKG_OUT_W - 1)) - 1;
   localparam int SAT_MIN = -(1 << (PKG_OUT_W - 1));

   localparam int unsigned VEC_Q_W = PKG_LANES * PKG_OUT_W;

   typedef logic [PKG_IN_W-1:0] lane_in_t;

   // One FIFO entry: two packed quantized vectors plus the tile-last marker
   typedef struct packed {
      logic               last;
      logic [VEC_Q_W-1:0] hi;
      logic [VEC_Q_W-1:0] lo;
   } word_t;

   // Extract lane idx from a flat sum vector; shift form avoids a wide
   // variable part-select index.
   function automatic lane_in_t lane_slice(input logic [PKG_LANES*PKG_IN_W-1:0] vec,
                                           input int unsigned idx);
      logic [PKG_LANES*PKG_IN_W-1:0] shifted;
      shifted = vec >> (idx * PKG_IN_W);
      return shifted[PKG_IN_W-1:0];
   endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane
//   Combinational requantizer for one lane: rounding arithmetic right shift,
//   optional ReLU, then saturation to a signed OUT_W-bit value. Arithmetic is
//   carried at IN_W+1 bits so the rounding bias can never overflow.
// Ports:
//   x_i       in  IN_W   signed input lane
//   shift_i   in  4      right-shift amount 0..15
//   relu_en_i in  1      clamp negative results to zero
//   q_o       out OUT_W  signed saturated result

module requant_lane
   import output_gating_pkg::*;
#(
   parameter int unsigned IN_W  = PKG_IN_W,
   parameter int unsigned OUT_W = PKG_OUT_W
) (
   input  logic [IN_W-1:0]    x_i,
   input  logic [SHIFT_W-1:0] shift_i,
   input  logic               relu_en_i,
   output logic [OUT_W-1:0]   q_o
);

   localparam int unsigned CW = IN_W + 1;
   localparam logic signed [CW-1:0] SatMax = CW'(SAT_MAX);
   localparam logic signed [CW-1:0] SatMin = CW'(SAT_MIN);

   logic signed [CW-1:0] x_ext;
   logic signed [CW-1:0] bias;
   logic signed [CW-1:0] sum;
   logic signed [CW-1:0] r;

   always_comb begin
      x_ext = $signed({x_i[IN_W-1], x_i});
      bias  = '0;
      if (shift_i != '0) begin
         bias = CW'(1) << (shift_i - SHIFT_W'(1));
      end
      sum = x_ext + bias;
      r   = sum >>> shift_i;

      if (relu_en_i && r[CW-1]) begin
         r = '0;
      end

      if (r > SatMax) begin
         q_o = SatMax[OUT_W-1:0];
      end else if (r < SatMin) begin
         q_o = SatMin[OUT_W-1:0];
      end else begin
         q_o = r[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count. A push while full is accepted only
//   if a pop happens in the same cycle; otherwise the push is ignored and the
//   pointers are left alone. Storage is zeroed on reset so the head reads 0.
// Ports:
//   clk_i   in  1      clock, rising edge
//   rst_i   in  1      synchronous active-high reset
//   push_i  in  1      write request
//   wdata_i in  WIDTH  write data
//   pop_i   in  1      read request (ignored when empty)
//   rdata_o out WIDTH  head entry
//   full_o  out 1      count == DEPTH
//   empty_o out 1      count == 0

module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      do_pop  = pop_i && !empty_o;
      // Full with a simultaneous pop frees the slot being written
      do_push = push_i && (!full_o || do_pop);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/output_gating.sv
// output_gating
//   Requantizes each incoming 16x16-bit sum vector to 16x int8, pairs two
//   consecutive results into one 256-bit word and queues the words in a small
//   FIFO drained through valid/ready. The upstream cannot stall, so a word that
//   finds the FIFO full is dropped and a sticky error is raised.
// Ports:
//   clk          in  1    clock, rising edge
//   rst          in  1    synchronous active-high reset
//   in_valid     in  1    sum vector present (no backpressure)
//   in_sum       in  256  16 signed 16-bit lanes
//   in_last      in  1    final vector of a tile
//   cfg_shift    in  4    rounding right-shift amount
//   cfg_relu_en  in  1    clamp negatives to zero
//   out_valid    out 1    FIFO head valid
//   out_data     out 256  {odd vector, even vector}
//   out_last     out 1    head word closes a tile
//   out_ready    in  1    downstream accepts the word
//   err_overflow out 1    sticky drop flag
//   word_cnt     out 16   accepted output words, wrapping

module output_gating
   import output_gating_pkg::*;
#(
   parameter int unsigned LANES      = PKG_LANES,
   parameter int unsigned IN_W       = PKG_IN_W,
   parameter int unsigned OUT_W      = PKG_OUT_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [LANES*IN_W-1:0]    in_sum,
   input  logic                     in_last,
   input  logic [SHIFT_W-1:0]       cfg_shift,
   input  logic                     cfg_relu_en,
   output logic                     out_valid,
   output logic [2*LANES*OUT_W-1:0] out_data,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic                     err_overflow,
   output logic [15:0]              word_cnt
);

   localparam int unsigned QW = LANES * OUT_W;

   // Stage 1: requantized vector
   logic [QW-1:0] q_d, q_q;
   logic          q_valid_q, q_last_q;

   // Stage 2: packer
   logic          half_q, half_d;
   logic [QW-1:0] lo_q, lo_d;
   logic          push;
   word_t         push_word;

   // FIFO side
   word_t         head_word;
   logic          fifo_full, fifo_empty, pop;
   logic          err_q, err_d;
   logic [15:0]   word_cnt_q, word_cnt_d;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      requant_lane #(
         .IN_W  (IN_W),
         .OUT_W (OUT_W)
      ) u_requant_lane (
         .x_i       (lane_slice(in_sum, i)),
         .shift_i   (cfg_shift),
         .relu_en_i (cfg_relu_en),
         .q_o       (q_d[i*OUT_W +: OUT_W])
      );
   end

   always_comb begin
      push      = 1'b0;
      push_word = '0;
      half_d    = half_q;
      lo_d      = lo_q;
      if (q_valid_q) begin
         if (half_q) begin
            push           = 1'b1;
            push_word.hi   = q_q;
            push_word.lo   = lo_q;
            push_word.last = q_last_q;
            half_d         = 1'b0;
         end else if (q_last_q) begin
            // Lone tile-closing vector: emit with an empty upper half
            push           = 1'b1;
            push_word.lo   = q_q;
            push_word.last = 1'b1;
         end else begin
            lo_d   = q_q;
            half_d = 1'b1;
         end
      end
   end

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;

   always_comb begin
      err_d      = err_q || (push && fifo_full && !pop);
      word_cnt_d = word_cnt_q + (pop ? 16'd1 : 16'd0);
   end

   sync_fifo #(
      .WIDTH ($bits(word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_sync_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i (push_word),
      .pop_i   (pop),
      .rdata_o (head_word),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_data     = {head_word.hi, head_word.lo};
   assign out_last     = head_word.last;
   assign err_overflow = err_q;
   assign word_cnt     = word_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q        <= '0;
         q_valid_q  <= 1'b0;
         q_last_q   <= 1'b0;
         half_q     <= 1'b0;
         lo_q       <= '0;
         err_q      <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         q_q        <= q_d;
         q_valid_q  <= in_valid;
         q_last_q   <= in_valid && in_last;
         half_q     <= half_d;
         lo_q       <= lo_d;
         err_q      <= err_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_output_gating.sv
// tb_output_gating
//   Directed bench for output_gating. Expected words come from an independent
//   integer requant model and are queued when stimulus is applied; they are
//   compared against the FIFO head whenever a handshake occurs.

module tb_output_gating;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [255:0] in_sum;
   logic         in_last;
   logic [3:0]   cfg_shift;
   logic         cfg_relu_en;
   logic         out_valid;
   logic [255:0] out_data;
   logic         out_last;
   logic         out_ready;
   logic         err_overflow;
   logic [15:0]  word_cnt;

   int checks  = 0;
   int errors  = 0;
   int drained = 0;
   logic [256:0] sb [$];

   always #5 clk = ~clk;

   output_gating u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_sum       (in_sum),
      .in_last      (in_last),
      .cfg_shift    (cfg_shift),
      .cfg_relu_en  (cfg_relu_en),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .err_overflow (err_overflow),
      .word_cnt     (word_cnt)
   );

   // Floor-division reference for the rounding shift
   function automatic logic [7:0] model_lane(input logic [15:0] x, input int sh, input bit relu);
      int v, p, r;
      logic [31:0] rv;
      v = int'($signed(x));
      if (sh == 0) begin
         r = v;
      end else begin
         p = 1 << sh;
         v = v + p / 2;
         if (v >= 0) r = v / p;
         else r = -((-v + p - 1) / p);
      end
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      rv = r;
      return rv[7:0];
   endfunction

   function automatic logic [127:0] model_vec(input logic [255:0] v);
      logic [127:0] q;
      for (int i = 0; i < 16; i++) begin
         q[i*8 +: 8] = model_lane(v[i*16 +: 16], int'(cfg_shift), cfg_relu_en);
      end
      return q;
   endfunction

   function automatic logic [255:0] rand_vec();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_pop();
      logic [256:0] e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL sb_underflow: observed word %h with none expected", {out_last, out_data});
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("pop_word", {out_last, out_data}, e);
         drained++;
      end
   endtask

   // One clock: compare any handshake at the falling edge, return 1 time unit
   // after the rising edge so inputs can be changed.
   task automatic tick();
      @(negedge clk);
      if (!rst && out_valid && out_ready) check_pop();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [255:0] v, input logic last);
      in_valid = 1'b1;
      in_sum   = v;
      in_last  = last;
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [255:0] va, vb, vc, vd, ve;
      logic [255:0] vv [10];
      int d0;

      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0;
      cfg_shift = 4'd4; cfg_relu_en = 1'b0; out_ready = 1'b1;
      idle(3);
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 257'(out_valid), 257'(1'b0));
      chk("rst_out_last", 257'(out_last), 257'(1'b0));
      chk("rst_out_data", 257'(out_data), 257'(0));
      chk("rst_err", 257'(err_overflow), 257'(1'b0));
      chk("rst_word_cnt", 257'(word_cnt), 257'(0));

      // Requant 256 >> 4 with latency
      va = {16{16'h0100}};
      sb.push_back({1'b0, model_vec(va), model_vec(va)});
      drive(va, 1'b0);
      drive(va, 1'b0);
      in_valid = 1'b0;
      chk("lat_not_yet", 257'(out_valid), 257'(1'b0));
      idle(1);
      chk("lat_valid", 257'(out_valid), 257'(1'b1));
      chk("requant_0x10", 257'(out_data), 257'({32{8'h10}}));
      idle(2);
      chk("wc_after_req", 257'(word_cnt), 257'(1));

      // Rounding without and with ReLU
      va = '0;
      va[15:0]  = 16'd24;
      va[31:16] = 16'hFFE8;
      sb.push_back({1'b1, 128'h0, model_vec(va)});
      drive(va, 1'b1);
      idle(1);
      chk("round_bytes", 257'(out_data[15:0]), 257'(16'hFF02));
      chk("round_last", 257'(out_last), 257'(1'b1));
      idle(2);
      cfg_relu_en = 1'b1;
      sb.push_back({1'b1, 128'h0, model_vec(va)});
      drive(va, 1'b1);
      idle(1);
      chk("relu_bytes", 257'(out_data[15:0]), 257'(16'h0002));
      idle(2);

      // Saturation at shift 0
      cfg_shift = 4'd0; cfg_relu_en = 1'b0;
      va = '0;
      va[15:0]  = 16'h7FFF;
      va[31:16] = 16'h8000;
      va[47:32] = 16'h0080;
      sb.push_back({1'b1, 128'h0, model_vec(va)});
      drive(va, 1'b1);
      idle(1);
      chk("sat_bytes", 257'(out_data[23:0]), 257'(24'h7F807F));
      idle(2);

      // Packing with last, then back-to-back last vectors
      do_reset();
      cfg_shift = 4'd3;
      va = rand_vec(); vb = rand_vec(); vc = rand_vec(); vd = rand_vec(); ve = rand_vec();
      sb.push_back({1'b0, model_vec(vb), model_vec(va)});
      sb.push_back({1'b1, 128'h0, model_vec(vc)});
      drive(va, 1'b0);
      drive(vb, 1'b0);
      drive(vc, 1'b1);
      idle(5);
      chk("pack_word_cnt", 257'(word_cnt), 257'(2));
      sb.push_back({1'b1, 128'h0, model_vec(vd)});
      sb.push_back({1'b1, 128'h0, model_vec(ve)});
      drive(vd, 1'b1);
      drive(ve, 1'b1);
      idle(5);
      chk("b2b_last_cnt", 257'(word_cnt), 257'(4));

      // Overflow: 10 vectors with downstream stalled
      out_ready = 1'b0;
      cfg_relu_en = 1'b1;
      for (int i = 0; i < 10; i++) vv[i] = rand_vec();
      for (int i = 0; i < 4; i++) sb.push_back({1'b0, model_vec(vv[2*i+1]), model_vec(vv[2*i])});
      for (int i = 0; i < 10; i++) drive(vv[i], 1'b0);
      in_valid = 1'b0;
      chk("ovf_before_drop", 257'(err_overflow), 257'(1'b0));
      idle(1);
      chk("ovf_after_drop", 257'(err_overflow), 257'(1'b1));
      chk("ovf_head_valid", 257'(out_valid), 257'(1'b1));
      chk("ovf_head_hold", 257'(out_data), 257'({model_vec(vv[1]), model_vec(vv[0])}));
      d0 = drained;
      out_ready = 1'b1;
      idle(8);
      chk("ovf_drained", 257'(drained - d0), 257'(4));
      chk("ovf_empty", 257'(out_valid), 257'(1'b0));
      chk("ovf_word_cnt", 257'(word_cnt), 257'(8));
      chk("ovf_sticky", 257'(err_overflow), 257'(1'b1));

      // Reset mid-stream with half held and 2 words queued
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) drive(rand_vec(), 1'b0);
      idle(1);
      chk("pre_rst_valid", 257'(out_valid), 257'(1'b1));
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      sb.delete();
      chk("mid_rst_valid", 257'(out_valid), 257'(1'b0));
      chk("mid_rst_word_cnt", 257'(word_cnt), 257'(0));
      chk("mid_rst_err", 257'(err_overflow), 257'(1'b0));
      out_ready = 1'b1;
      va = rand_vec(); vb = rand_vec();
      sb.push_back({1'b0, model_vec(vb), model_vec(va)});
      drive(va, 1'b0);
      drive(vb, 1'b0);
      idle(4);
      chk("post_rst_word_cnt", 257'(word_cnt), 257'(1));
      chk("sb_empty", 257'(sb.size()), 257'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
